disk_fill_arbiter: RTL and testbench
====================================

// Module: disk_fill_arbiter
// PURPOSE
//   Shares the single instruction hard disk between two miss requesters:
//   req 0 = instruction cache, req 1 = SPE/local-store loader.
//   - Picks one miss at a time (round-robin) and issues it to the disk as a one-cycle miss pulse.
//   - Holds the disk address stable until the disk reports valid.
//   - Registers the 32-word line and returns it to the winner with a one-cycle response strobe.
//   - Sits between the cache miss logic and the hardDisk model.
// PARAMETERS
//   WAIT_MAX  8   cycles in WAIT without disk_valid before the request is aborted (timeout)
//   STARTUP   4   cycles held in STARTUP after reset release so the disk penalty counter drains
//   ALIGN     1   1: zero address bits [25:31] (32-word line boundary); 0: pass address through
// PORTS
//   clk           in   1          single clock, all state on posedge
//   reset         in   1          asynchronous, active-low; state clears while reset==0
//   req0, req1    in   1          level miss request; held until the matching rsp strobe
//   addr0, addr1  in   [0:31]     missed byte address for each requester
//   rsp0_valid    out  1          1-cycle strobe: rsp_line holds requester 0's line
//   rsp1_valid    out  1          1-cycle strobe: rsp_line holds requester 1's line
//   rsp_line      out  [0:31][0:31]  registered 32-word fill line, shared by both requesters
//   disk_miss     out  1          to the disk's miss input; high for exactly one cycle per request
//   disk_addr     out  [0:31]    to the disk's missedPC; stable from ISSUE through the valid cycle
//   disk_valid    in   1          from the disk's valid output
//   disk_line     in   [0:31][0:31]  from the disk's instr32 output; sampled only when disk_valid=1
//   busy          out  1          1 in any state other than IDLE
//   grant_id      out  1          requester being served; meaningful while busy
//   timeout_err   out  1          1-cycle strobe when a WAIT times out
// BEHAVIOUR
//   Reset (reset==0), asynchronous:
//     - state=STARTUP, start counter=0, last_grant=1 (so requester 0 wins first).
//     - All outputs 0; rsp_line=0; mask=none.
//   States: STARTUP, IDLE, ISSUE, WAIT, RESP.
//   STARTUP: counts STARTUP cycles, ignores requests, then goes to IDLE.
//   IDLE:
//     - Eligible = reqN=1 and N is not masked.
//     - Both eligible: winner = !last_grant. One eligible: that one.
//     - On a winner: latch grant_id and disk_addr (aligned per ALIGN), update last_grant,
//       go to ISSUE. Clear the mask either way.
//   ISSUE: disk_miss=1 for this cycle only; go to WAIT; clear the wait counter.
//   WAIT:
//     - disk_valid=1: capture disk_line into rsp_line at this posedge, go to RESP.
//     - Wait counter reaches WAIT_MAX first: timeout_err=1 for 1 cycle, go to IDLE,
//       no mask (the request is retried).
//   RESP:
//     - rsp{grant_id}_valid=1 for one cycle.
//     - Mask grant_id for the next IDLE cycle (the requester drops req after the strobe).
//     - Go to IDLE.
//   Disk timing: miss in ISSUE; penalty 1, 2, 3 in the next three cycles; valid in the 3rd
//     WAIT cycle. Nominal latency: req seen in IDLE at cycle 0 -> rsp strobe in cycle 5.
//     Back-to-back service period is 6 cycles.
//   disk_valid outside WAIT is ignored: no capture, no state change.
//   disk_addr holds its last value when idle. rsp_line holds until the next capture.
//   A new reqN arriving during service waits; its addrN is sampled only in IDLE.
//   Reset mid-transaction aborts it: no rsp strobe, and STARTUP hides the disk's residual count.
//   Registered outputs (reset to 0): rsp_line, disk_addr, grant_id.
//   Outputs decoded from state: busy, disk_miss, rsp*_valid, timeout_err.
// STRUCTURE
//   Package disk_pkg:
//     - typedef enum logic [2:0] fill_state_t {STARTUP, IDLE, ISSUE, WAIT, RESP}
//     - typedef logic [0:31][0:31] line_t
//     - localparam DISK_LAT = 4
//     - function line_align()
//   Sub-module rr_arb2: 2-way round-robin pick from req, mask and last_grant.
//     Combinational, outputs gnt_valid and gnt_id.
// TESTING
//   1. Reset low, then high; req0=1, addr0=0x84 after STARTUP ->
//      disk_miss 1 cycle later with disk_addr=0x80; rsp0_valid 5 cycles after IDLE;
//      rsp_line = mem[0x20..0x3F].
//   2. req0 and req1 rise together, addr0=0x000, addr1=0x100 ->
//      serve 0 first, then 1; rsp strobes 6 cycles apart; grant_id 0 then 1.
//   3. req0 held high continuously with req1 pending -> strict alternation 0, 1, 0, 1;
//      no two consecutive grants to the same requester.
//   4. Disk stub never asserts valid -> timeout_err after WAIT_MAX=8 WAIT cycles,
//      no rsp strobe, reissue on the next IDLE cycle.
//   5. reset=0 during the 2nd WAIT cycle -> all outputs 0 immediately;
//      after release no rsp strobe, STARTUP lasts 4 cycles, then a fresh request is served correctly.
//   6. disk_valid pulsed while IDLE -> no capture; rsp_line unchanged; no strobe.

Source files
------------

// File: rtl/disk_pkg.sv
// rtl/disk_pkg.sv - shared types and helpers for the instruction disk fill arbiter
package disk_pkg;

    typedef enum logic [2:0] {
        STARTUP,
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } fill_state_t;

    typedef logic [0:31][0:31] line_t;

    // miss cycle plus three penalty cycles before the disk reports valid
    localparam int DISK_LAT = 4;

    // Clear the byte offset within a 32-word (128-byte) line.
    function automatic logic [0:31] line_align(input logic [0:31] addr);
        return {addr[0:24], 7'b0};
    endfunction

endpackage

// File: rtl/disk_fill_arbiter_if.sv
// rtl/disk_fill_arbiter_if.sv - requester and disk side signals of the fill arbiter
interface disk_fill_arbiter_if
    import disk_pkg::*;
;
    logic        req0;
    logic        req1;
    logic [0:31] addr0;
    logic [0:31] addr1;
    logic        rsp0_valid;
    logic        rsp1_valid;
    line_t       rsp_line;
    logic        disk_miss;
    logic [0:31] disk_addr;
    logic        disk_valid;
    line_t       disk_line;
    logic        busy;
    logic        grant_id;
    logic        timeout_err;

    modport master (
        input  req0, req1, addr0, addr1, disk_valid, disk_line,
        output rsp0_valid, rsp1_valid, rsp_line, disk_miss, disk_addr,
               busy, grant_id, timeout_err
    );

    modport slave (
        output req0, req1, addr0, addr1, disk_valid, disk_line,
        input  rsp0_valid, rsp1_valid, rsp_line, disk_miss, disk_addr,
               busy, grant_id, timeout_err
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick from request, mask and last grant
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       last_grant_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    logic [1:0] elig;

    assign elig        = req_i & ~mask_i;
    assign gnt_valid_o = |elig;
    // contention goes to whoever did not win last; otherwise the lone eligible one
    assign gnt_id_o    = (&elig) ? ~last_grant_i : elig[1];

endmodule

// File: rtl/disk_fill_arbiter.sv
// rtl/disk_fill_arbiter.sv - shares the instruction disk between the icache and the SPE loader
module disk_fill_arbiter
    import disk_pkg::*;
#(
    parameter int WAIT_MAX = 8,
    parameter int STARTUP  = 4,
    parameter bit ALIGN    = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    disk_fill_arbiter_if.master        bus
);

    localparam int CNT_MAX = (WAIT_MAX > STARTUP)
                           ? ((WAIT_MAX > DISK_LAT) ? WAIT_MAX : DISK_LAT)
                           : ((STARTUP  > DISK_LAT) ? STARTUP  : DISK_LAT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    fill_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_grant_q;
    logic             grant_id_q;
    logic             timeout_q;
    logic [1:0]       mask_q;
    logic [0:31]      disk_addr_q;
    line_t            rsp_line_q;

    logic             gnt_valid;
    logic             gnt_id;
    logic [0:31]      gnt_addr;

    rr_arb2 u_rr_arb2 (
        .req_i        ({bus.req1, bus.req0}),
        .mask_i       (mask_q),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_id_o     (gnt_id)
    );

    assign gnt_addr = gnt_id ? bus.addr1 : bus.addr0;

    // cnt_q counts STARTUP cycles first, then WAIT cycles of each request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= disk_pkg::STARTUP;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            timeout_q    <= 1'b0;
            mask_q       <= '0;
            disk_addr_q  <= '0;
            rsp_line_q   <= '0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                disk_pkg::STARTUP: begin
                    if (cnt_q == CNT_W'(STARTUP - 1)) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                IDLE: begin
                    mask_q <= '0;
                    if (gnt_valid) begin
                        grant_id_q   <= gnt_id;
                        last_grant_q <= gnt_id;
                        disk_addr_q  <= ALIGN ? line_align(gnt_addr) : gnt_addr;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.disk_valid) begin
                        rsp_line_q <= bus.disk_line;
                        state_q    <= RESP;
                    end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                        // no mask: the same requester is retried on the next IDLE cycle
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    mask_q  <= {grant_id_q, ~grant_id_q};
                    state_q <= IDLE;
                end
                default: state_q <= disk_pkg::STARTUP;
            endcase
        end
    end

    // busy stays low in STARTUP so every output reads zero straight out of reset
    assign bus.busy        = (state_q == ISSUE) || (state_q == WAIT) || (state_q == RESP);
    assign bus.disk_miss   = (state_q == ISSUE);
    assign bus.rsp0_valid  = (state_q == RESP) && !grant_id_q;
    assign bus.rsp1_valid  = (state_q == RESP) &&  grant_id_q;
    assign bus.timeout_err = timeout_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.disk_addr   = disk_addr_q;
    assign bus.rsp_line    = rsp_line_q;

endmodule

// File: tb/tb_disk_fill_arbiter.sv
// tb/tb_disk_fill_arbiter.sv - scoreboard bench for disk_fill_arbiter with a disk stub
module tb_disk_fill_arbiter;
    import disk_pkg::*;

    typedef struct {
        logic        id;
        logic [31:0] addr;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pend     = 0;
    int miss_cnt = 0;
    int last_miss_cyc = -1;
    int to_cnt   = 0;
    int last_to_cyc = -1;
    logic [31:0] miss_addr = '0;
    logic [31:0] last_miss_addr = '0;
    bit mute = 1'b0;
    bit force_valid = 1'b0;
    bit prev_miss = 1'b0;

    logic [31:0] reqq0[$];
    logic [31:0] reqq1[$];
    exp_t        sb[$];

    always #5 clk = ~clk;

    disk_fill_arbiter_if bus ();

    disk_fill_arbiter #(
        .WAIT_MAX (8),
        .STARTUP  (4),
        .ALIGN    (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] w);
        return {w[15:0] ^ 16'h5A3C, ~w[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        exp_t        e;
        int          nbad;
        logic [31:0] base;
        bit          genuine;
        @(negedge clk);
        cyc++;
        if (bus.rsp0_valid || bus.rsp1_valid) begin
            check("rsp_onehot", bus.rsp0_valid & bus.rsp1_valid, 0);
            if (sb.size() == 0) begin
                check("rsp_unexpected", bus.rsp0_valid | bus.rsp1_valid, 0);
            end else begin
                e    = sb.pop_front();
                base = (e.addr & ~32'h7F) >> 2;
                nbad = 0;
                for (int k = 0; k < 32; k++)
                    if (bus.rsp_line[k] !== mem_word(base + 32'(k))) nbad++;
                check("rsp_id", bus.rsp1_valid, e.id);
                check("rsp_grant_id", bus.grant_id, e.id);
                check("rsp_cycle", cyc, e.cyc);
                check("rsp_word0", bus.rsp_line[0], mem_word(base));
                check("rsp_bad_words", nbad, 0);
            end
            if (bus.rsp0_valid && reqq0.size() > 0) void'(reqq0.pop_front());
            if (bus.rsp1_valid && reqq1.size() > 0) void'(reqq1.pop_front());
        end
        if (bus.timeout_err) begin
            to_cnt++;
            last_to_cyc = cyc;
        end
        // disk stub: valid on the third cycle after the miss cycle
        genuine = 1'b0;
        if (pend > 0) begin
            pend--;
            genuine = (pend == 0) && !mute;
        end
        if (genuine) begin
            bus.disk_valid = 1'b1;
            for (int k = 0; k < 32; k++)
                bus.disk_line[k] = mem_word((miss_addr >> 2) + 32'(k));
            if (bus.busy) check("disk_addr_stable", bus.disk_addr, miss_addr);
        end else begin
            bus.disk_valid = force_valid;
            bus.disk_line  = '1;
        end
        if (bus.disk_miss) begin
            check("miss_pulse_width", prev_miss, 0);
            miss_cnt++;
            last_miss_cyc  = cyc;
            miss_addr      = bus.disk_addr;
            last_miss_addr = bus.disk_addr;
            pend           = DISK_LAT - 1;
        end
        prev_miss = bus.disk_miss;
        bus.req0 = (reqq0.size() > 0);
        if (reqq0.size() > 0) bus.addr0 = reqq0[0];
        bus.req1 = (reqq1.size() > 0);
        if (reqq1.size() > 0) bus.addr1 = reqq1[0];
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", bus.busy, 0);
        check("rst_disk_miss", bus.disk_miss, 0);
        check("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
        check("rst_timeout", bus.timeout_err, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_disk_addr", bus.disk_addr, 0);
        check("rst_rsp_line", |bus.rsp_line, 0);
    endtask

    task automatic hold_reset(input int n, output int rel);
        reset = 1'b0;
        reqq0.delete();
        reqq1.delete();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (n) tick();
        check_reset_outputs();
        reset = 1'b1;
        rel   = cyc;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", {sb.size() != 0, bus.busy}, 0);
        repeat (2) tick();
    endtask

    initial begin
        int r;
        int t;
        int mc0;
        int tc0;
        bus.req0       = 1'b0;
        bus.req1       = 1'b0;
        bus.addr0      = '0;
        bus.addr1      = '0;
        bus.disk_valid = 1'b0;
        bus.disk_line  = '1;

        // 1: single request after STARTUP, aligned address
        hold_reset(3, r);
        reqq0.push_back(32'h84);
        sb.push_back('{1'b0, 32'h84, r + 9});
        run_until_idle(40);
        check("t1_miss_cycle", last_miss_cyc, r + 5);
        check("t1_disk_addr", last_miss_addr, 32'h80);

        // 2: simultaneous requests, requester 0 first, strobes 6 apart
        hold_reset(2, r);
        reqq0.push_back(32'h000);
        reqq1.push_back(32'h100);
        sb.push_back('{1'b0, 32'h000, r + 9});
        sb.push_back('{1'b1, 32'h100, r + 15});
        run_until_idle(60);

        // 3: requester 0 continuously high, strict alternation
        t = cyc + 1;
        reqq0.push_back(32'h400); reqq0.push_back(32'h480); reqq0.push_back(32'h500);
        reqq1.push_back(32'h600); reqq1.push_back(32'h680);
        sb.push_back('{1'b0, 32'h400, t + 5});
        sb.push_back('{1'b1, 32'h600, t + 11});
        sb.push_back('{1'b0, 32'h480, t + 17});
        sb.push_back('{1'b1, 32'h680, t + 23});
        sb.push_back('{1'b0, 32'h500, t + 29});
        run_until_idle(80);

        // 4: disk never answers, timeout then reissue
        mute = 1'b1;
        mc0  = miss_cnt;
        tc0  = to_cnt;
        t    = cyc + 1;
        reqq0.push_back(32'h200);
        repeat (12) tick();
        check("t4_timeout_count", to_cnt - tc0, 1);
        check("t4_timeout_cycle", last_to_cyc, t + 10);
        check("t4_miss_count", miss_cnt - mc0, 2);
        check("t4_reissue_cycle", last_miss_cyc, t + 11);
        mute = 1'b0;
        sb.push_back('{1'b0, 32'h200, t + 15});
        run_until_idle(40);

        // 5: reset during the 2nd WAIT cycle aborts, then a fresh request
        t = cyc + 1;
        reqq0.push_back(32'h300);
        repeat (4) tick();
        check("t5_busy_before_reset", bus.busy, 1);
        reset = 1'b0;
        reqq0.delete();
        bus.req0 = 1'b0;
        #1;
        check_reset_outputs();
        reset = 1'b1;
        r = cyc;
        reqq1.push_back(32'h3C4);
        sb.push_back('{1'b1, 32'h3C4, r + 9});
        run_until_idle(40);
        check("t5_miss_cycle", last_miss_cyc, r + 5);
        check("t5_disk_addr", last_miss_addr, 32'h380);

        // 6: disk_valid while IDLE is ignored
        force_valid = 1'b1;
        tick();
        force_valid = 1'b0;
        repeat (2) tick();
        check("t6_busy", bus.busy, 0);
        check("t6_rsp_word0", bus.rsp_line[0], mem_word(32'h380 >> 2));
        check("t6_rsp_word31", bus.rsp_line[31], mem_word((32'h380 >> 2) + 32'd31));

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
